// File: rtl/dmc_dma_fetch_pkg.sv
// Shared types and constants for the DMC DMA fetch unit.
package dmc_fetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int STALL_BASE = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_DUMMY = 3'd2,
    ST_ALIGN = 3'd3,
    ST_FETCH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/dmc_dma_fetch_if.sv
// CPU/channel/memory signal bundle of the DMC DMA fetch unit; master is the fetch unit.
interface dmc_dma_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              phi_en;
  logic              cpu_rnw;
  logic              dmc_req;
  logic [ADDR_W-1:0] dmc_addr;
  logic              rdy;
  logic              absel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] dmc_data;
  logic              dmc_valid;

  modport master (
    input  phi_en, cpu_rnw, dmc_req, dmc_addr, mem_ack, mem_data,
    output rdy, absel, mem_addr, mem_rd, dmc_data, dmc_valid
  );

  modport slave (
    output phi_en, cpu_rnw, dmc_req, dmc_addr, mem_ack, mem_data,
    input  rdy, absel, mem_addr, mem_rd, dmc_data, dmc_valid
  );
endinterface

// File: rtl/dmc_dma_fetch_getput_phase.sv
// Get/put phase flag: toggles on every CPU cycle boundary, cleared by reset.
module dmc_getput_phase (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_phi_en,
  output logic o_put
);
  logic r_put;

  always_ff @(posedge i_clk) begin
    if (i_res) r_put <= 1'b0;
    else if (i_phi_en) r_put <= ~r_put;
  end

  assign o_put = r_put;
endmodule

// File: rtl/dmc_dma_fetch.sv
// DMC DMA fetch: stalls the CPU via RDY, reads one sample byte over the memory handshake.
// DMC_GETPUT_ALIGN_EN enables get/put tracking and the ALIGN state.
module dmc_dma_fetch
  import dmc_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic           i_clk,
  input  logic           i_res,
  dmc_dma_fetch_if.master bus
);
  // state | meaning
  // IDLE  | no request, RDY high
  // HALT  | RDY low, waiting for a CPU read cycle (writes ignore RDY)
  // DUMMY | CPU halted on a read, request committed
  // ALIGN | burn one put cycle so the fetch lands on a get cycle
  // FETCH | DMC owns the address bus, read outstanding
  // DONE  | byte captured, release CPU at next cycle boundary
  state_t            r_state;
  logic              r_rdy;
  logic              r_absel;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_dmc_data;
  logic              r_dmc_valid;
  logic              w_fetch_now;

`ifdef DMC_GETPUT_ALIGN_EN
  logic w_put;

  dmc_getput_phase u_phase (
    .i_clk   (i_clk),
    .i_res   (i_res),
    .i_phi_en(bus.phi_en),
    .o_put   (w_put)
  );

  // PUT is about to toggle; fetch now only if the coming cycle is a get (PUT=0)
  assign w_fetch_now = w_put;
`else
  assign w_fetch_now = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state     <= ST_IDLE;
      r_rdy       <= 1'b1;
      r_absel     <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_dmc_data  <= '0;
      r_dmc_valid <= 1'b0;
    end else begin
      r_dmc_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.phi_en && bus.dmc_req) begin
            r_state <= ST_HALT;
            r_rdy   <= 1'b0;
          end
        end
        ST_HALT: begin
          if (bus.phi_en) begin
            if (!bus.dmc_req) begin
              r_state <= ST_IDLE;
              r_rdy   <= 1'b1;
            end else if (bus.cpu_rnw) begin
              r_state <= ST_DUMMY;
            end
          end
        end
        ST_DUMMY: begin
          if (bus.phi_en) begin
            r_mem_addr <= bus.dmc_addr;
            if (w_fetch_now) begin
              r_state <= ST_FETCH;
              r_absel <= 1'b1;
            end else begin
              r_state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (bus.phi_en) begin
            r_state <= ST_FETCH;
            r_absel <= 1'b1;
          end
        end
        ST_FETCH: begin
          // an ack only counts once the read request is visible on the bus
          if (r_mem_rd && bus.mem_ack) begin
            r_dmc_data <= bus.mem_data;
            r_mem_rd   <= 1'b0;
            r_absel    <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_mem_rd <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.phi_en) begin
            r_rdy       <= 1'b1;
            r_dmc_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdy       = r_rdy;
  assign bus.absel     = r_absel;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.dmc_data  = r_dmc_data;
  assign bus.dmc_valid = r_dmc_valid;
endmodule

// File: tb/tb_dmc_dma_fetch.sv
// Directed bench for dmc_dma_fetch; expectations follow DMC_GETPUT_ALIGN_EN if defined.
module tb_dmc_dma_fetch;
  logic clk = 1'b0;
  logic res = 1'b0;
  int   total = 0;
  int   bad = 0;

  int clk_cnt = 0;
  int phi_since_rst = 0;
  int tick_idx = 0;
  int n_wr = 0;
  int stall = 0;
  int valid_cnt = 0;
  int abs_seen = 0;
  int rd_clks = 0;
  int wait_cnt = 0;
  int ack_dly = 0;
  bit ack_en = 1'b0;
  logic [7:0] rd_data = 8'h00;

  dmc_dma_fetch_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  dmc_dma_fetch u_dut (
    .i_clk(clk),
    .i_res(res),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // PHI_EN every 4th clock; memory answers MEM_Rd after ack_dly extra clocks
  task automatic cyc();
    logic phi;
    logic rdy_pre;
    phi = (clk_cnt % 4 == 3);
    bus.phi_en  = phi;
    bus.cpu_rnw = (tick_idx >= 1 && tick_idx <= n_wr) ? 1'b0 : 1'b1;
    rdy_pre = bus.rdy;
    @(posedge clk);
    #1;
    clk_cnt++;
    if (res) phi_since_rst = 0;
    else if (phi) begin
      phi_since_rst++;
      tick_idx++;
      if (!rdy_pre || !bus.rdy) stall++;
    end
    if (bus.dmc_valid) valid_cnt++;
    if (bus.absel) abs_seen++;
    if (bus.mem_ack) bus.mem_ack = 1'b0;
    else if (bus.mem_rd) begin
      rd_clks++;
      if (ack_en && wait_cnt >= ack_dly) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = rd_data;
        wait_cnt     = 0;
      end else wait_cnt++;
    end
  endtask

  task automatic clear_counts();
    stall = 0; valid_cnt = 0; abs_seen = 0; rd_clks = 0; wait_cnt = 0;
  endtask

  task automatic align_to_tick();
    while (clk_cnt % 4 != 3) cyc();
  endtask

  // Expected RDY-low span in PHI_EN ticks, counting the falling and rising ticks
  function automatic int exp_stall(input int put0, input int k, input int dly);
    int al;
    al = 0;
`ifdef DMC_GETPUT_ALIGN_EN
    if (((put0 ^ k) & 1) == 0) al = 1;
`endif
    return 4 + k + al + (dly + 2) / 4;
  endfunction

  task automatic run_fetch(input logic [15:0] addr, input logic [7:0] data,
                           input int k, input int dly, input int want_put);
    align_to_tick();
    if ((phi_since_rst % 2) != want_put) begin
      cyc();
      align_to_tick();
    end
    clear_counts();
    n_wr = k; ack_dly = dly; ack_en = 1'b1; rd_data = data;
    bus.dmc_addr = addr;
    bus.dmc_req  = 1'b1;
    tick_idx = 0;
    for (int i = 0; i < 600 && valid_cnt == 0; i++) cyc();
    bus.dmc_req = 1'b0;
    n_wr = 0;
    repeat (8) cyc();
  endtask

  task automatic do_reset();
    res = 1'b1;
    bus.dmc_req = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) cyc();
    res = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", bus.rdy); end
    total++; if (bus.absel !== 1'b0) begin bad++; $display("FAIL reset_absel got=%b want=0", bus.absel); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b want=0", bus.mem_rd); end
    total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got=%h want=0000", bus.mem_addr); end
    total++; if (bus.dmc_data !== 8'h00) begin bad++; $display("FAIL reset_dmc_data got=%h want=00", bus.dmc_data); end
    total++; if (bus.dmc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.dmc_valid); end
  endtask

  task automatic test_fetch();
    logic [15:0] addrs [2];
    logic [7:0]  datas [2];
    int exp;
    addrs[0] = 16'hF000; datas[0] = 8'h3C;
    addrs[1] = 16'hC0A5; datas[1] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      exp = exp_stall(p, 0, 0);
      run_fetch(addrs[p], datas[p], 0, 0, p);
      total++; if (stall !== exp) begin bad++; $display("FAIL fetch_stall put=%0d got=%0d want=%0d", p, stall, exp); end
      total++; if (valid_cnt !== 1) begin bad++; $display("FAIL fetch_valid_cnt put=%0d got=%0d want=1", p, valid_cnt); end
      total++; if (bus.dmc_data !== datas[p]) begin bad++; $display("FAIL fetch_data put=%0d got=%h want=%h", p, bus.dmc_data, datas[p]); end
      total++; if (bus.mem_addr !== addrs[p]) begin bad++; $display("FAIL fetch_addr put=%0d got=%h want=%h", p, bus.mem_addr, addrs[p]); end
      total++; if (rd_clks !== 1) begin bad++; $display("FAIL fetch_rd_clks put=%0d got=%0d want=1", p, rd_clks); end
      total++; if (abs_seen !== 2) begin bad++; $display("FAIL fetch_absel_clks put=%0d got=%0d want=2", p, abs_seen); end
      total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL fetch_rdy_end put=%0d got=%b want=1", p, bus.rdy); end
    end
  endtask

  task automatic test_write_hold();
    int exp;
    for (int p = 0; p < 2; p++) begin
      exp = exp_stall(p, 3, 0);
      run_fetch(16'hF000, 8'h3C, 3, 0, p);
      total++; if (stall !== exp) begin bad++; $display("FAIL write_stall put=%0d got=%0d want=%0d", p, stall, exp); end
      total++; if (valid_cnt !== 1) begin bad++; $display("FAIL write_valid_cnt put=%0d got=%0d want=1", p, valid_cnt); end
    end
  endtask

  task automatic test_abort();
    align_to_tick();
    clear_counts();
    ack_en = 1'b1; ack_dly = 0;
    bus.dmc_addr = 16'h1234;
    bus.dmc_req  = 1'b1;
    tick_idx = 0;
    cyc();
    bus.dmc_req = 1'b0;
    repeat (4) cyc();
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b want=1", bus.rdy); end
    total++; if (stall !== 2) begin bad++; $display("FAIL abort_stall got=%0d want=2", stall); end
    repeat (12) cyc();
    total++; if (rd_clks !== 0) begin bad++; $display("FAIL abort_mem_rd got=%0d want=0", rd_clks); end
    total++; if (valid_cnt !== 0) begin bad++; $display("FAIL abort_valid got=%0d want=0", valid_cnt); end
  endtask

  task automatic test_ack_delay();
    int exp;
    exp = exp_stall(0, 0, 40);
    run_fetch(16'hF000, 8'hC7, 0, 40, 0);
    total++; if (stall !== exp) begin bad++; $display("FAIL delay_stall got=%0d want=%0d", stall, exp); end
    total++; if (rd_clks !== 41) begin bad++; $display("FAIL delay_rd_clks got=%0d want=41", rd_clks); end
    total++; if (valid_cnt !== 1) begin bad++; $display("FAIL delay_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (bus.dmc_data !== 8'hC7) begin bad++; $display("FAIL delay_data got=%h want=c7", bus.dmc_data); end
  endtask

  task automatic test_reset_mid();
    align_to_tick();
    clear_counts();
    ack_en = 1'b0;
    bus.dmc_addr = 16'hABCD;
    bus.dmc_req  = 1'b1;
    tick_idx = 0;
    for (int i = 0; i < 100 && rd_clks == 0; i++) cyc();
    total++; if (rd_clks == 0) begin bad++; $display("FAIL mid_reach_fetch got=0 want=nonzero"); end
    repeat (3) cyc();
    res = 1'b1;
    bus.dmc_req = 1'b0;
    cyc();
    res = 1'b0;
    valid_cnt = 0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = 8'hEE;
    cyc();
    repeat (12) cyc();
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy got=%b want=1", bus.rdy); end
    total++; if (bus.absel !== 1'b0) begin bad++; $display("FAIL mid_absel got=%b want=0", bus.absel); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL mid_mem_rd got=%b want=0", bus.mem_rd); end
    total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL mid_mem_addr got=%h want=0000", bus.mem_addr); end
    total++; if (bus.dmc_data !== 8'h00) begin bad++; $display("FAIL mid_dmc_data got=%h want=00", bus.dmc_data); end
    total++; if (valid_cnt !== 0) begin bad++; $display("FAIL mid_valid got=%0d want=0", valid_cnt); end
  endtask

  initial begin
    bus.phi_en   = 1'b0;
    bus.cpu_rnw  = 1'b1;
    bus.dmc_req  = 1'b0;
    bus.dmc_addr = 16'h0000;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h00;
    test_reset();
    test_fetch();
    test_write_hold();
    test_abort();
    test_ack_delay();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/dmc_dma_fetch.md
# dmc_dma_fetch

DMA fetch unit sitting directly upstream of the DPCM channel: takes its sample-byte request and address, stalls the CPU through RDY, performs the read on the shared memory bus with a request/acknowledge handshake, and returns the byte to the channel's sample buffer. It replaces the ad-hoc sample memory used in DPCM channel benches and is the block that owns address-bus takeover for DMC DMA.

## Interface
- ADDR_W, 16, width of DMC and memory addresses
- DATA_W, 8, width of data bus
- CLK  in  1  master clock
- RES  in  1  synchronous reset, active-high
- PHI_EN  in  1  one-CLK strobe marking each CPU cycle boundary; all cycle counts below are in PHI_EN ticks
- CPU_RnW  in  1  CPU cycle type of the cycle ending at PHI_EN (1 = read)
- DMC_Req  in  1  DPCM channel wants a byte (the inverse of its n_DMCAB)
- DMC_Addr  in  ADDR_W  sample address from the channel
- RDY  out  1  CPU ready; 0 stalls CPU read cycles
- ABSel  out  1  1 = memory address bus driven by DMC
- MEM_Addr  out  ADDR_W  memory read address
- MEM_Rd  out  1  memory read request, level
- MEM_Ack  in  1  memory acknowledge, one CLK; MEM_Data valid same clock
- MEM_Data  in  DATA_W  read data
- DMC_Data  out  DATA_W  fetched sample byte
- DMC_Valid  out  1  one-CLK pulse, DMC_Data valid

## Operation
- States: IDLE, HALT, DUMMY, ALIGN, FETCH, DONE. Transitions evaluated on PHI_EN clocks except FETCH exit.
- IDLE: PHI_EN & DMC_Req -> HALT.
- HALT: RDY=0. PHI_EN & !DMC_Req -> IDLE (abort, no Valid). PHI_EN & CPU_RnW=1 -> DUMMY. PHI_EN & CPU_RnW=0 -> stay (CPU ignores RDY on writes; up to 3 consecutive).
- DUMMY: committed; DMC_Req ignored from here. PHI_EN -> FETCH if toggled PUT=0, else ALIGN. MEM_Addr <= DMC_Addr latched on this transition.
- ALIGN: PHI_EN -> FETCH.
- FETCH: ABSel=1, MEM_Rd=1 held until MEM_Ack; on MEM_Ack clock capture MEM_Data -> DMC_Data, go DONE (no PHI_EN needed). Extra PHI_EN ticks while waiting keep RDY=0.
- DONE: on PHI_EN: RDY<=1, DMC_Valid pulse, -> IDLE. New request may be accepted at the next PHI_EN.
- PUT phase flag toggles every PHI_EN regardless of state; fetch always occupies a get cycle (PUT=0).

## Timing
- Reset values: RDY=1, ABSel=0, MEM_Rd=0, MEM_Addr=0, DMC_Data=0, DMC_Valid=0, PUT=0, state IDLE.
- All outputs registered. MEM_Rd rises the CLK after entry to FETCH; falls the CLK after MEM_Ack.
- Stall length with zero write cycles and Ack within one CPU cycle: 4 CPU cycles (halt, dummy, fetch, done) aligned, 5 with ALIGN.
- RES mid-operation: immediate return to reset values; in-flight read abandoned, no DMC_Valid; a late MEM_Ack after reset is ignored.
- MEM_Ack while MEM_Rd=0: ignored.

## Configuration
- DMC_GETPUT_ALIGN_EN defined: PUT tracking and ALIGN state active as above.
- Undefined: PUT flag removed, DUMMY always -> FETCH; stall is fixed 4 CPU cycles plus memory wait and write-cycle holds.

## Structure
- Package dmc_fetch_pkg: state encoding, STALL_BASE=4 constant, default widths.
- One sub-module: dmc_getput_phase (PUT flag toggle on PHI_EN, synchronous reset), instantiated only under DMC_GETPUT_ALIGN_EN.

## Test plan
- Reset, DMC_Req=1, DMC_Addr=F000, memory acks next CLK with 0x3C, all CPU reads -> RDY low for 4 or 5 PHI_EN ticks per PUT phase, MEM_Addr=F000, DMC_Data=3C with one Valid pulse.
- Same request with CPU_RnW=0 for 3 ticks in HALT -> DUMMY delayed exactly 3 ticks, total RDY-low 7/8 ticks.
- DMC_Req dropped during HALT -> IDLE, RDY=1 next PHI_EN, MEM_Rd never asserted, no Valid.
- MEM_Ack delayed 40 CLKs (several PHI_EN) -> MEM_Rd held, RDY held low, data captured on Ack, Valid once.
- RES asserted in FETCH then Ack arrives -> all outputs at reset values, no Valid, Ack ignored.
- Macro undefined, request started on both PUT phases -> stall identical 4 ticks both times.
